sync_fifo_param: RTL

Single-clock, parametrised FIFO for same-domain buffering, where the asynchronous FIFO's pointer synchronisers are unnecessary. It generalises the asynchronous FIFO's width/depth parameters and adds:
- selectable first-word-fall-through (FWFT) read mode;
- programmable almost-full and almost-empty thresholds;
- occupancy count;
- sticky overflow and underflow error flags;
- synchronous flush.

---
 rtl/sync_fifo_param_if.sv | 32 +++
 rtl/sync_fifo_param.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The FIFO connects through the slave modport; its user connects through the master modport.
interface sync_fifo_param_if #(
  parameter int unsigned DATASIZE = 64,
  parameter int unsigned ADDRSIZE = 7
);
  logic                clr;
  logic                w_en;
  logic [DATASIZE-1:0] wdata;
  logic                r_en;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                wfull;
  logic                rempty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output clr, w_en, wdata, r_en,
    input  rdata, rvalid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, w_en, wdata, r_en,
    output rdata, rvalid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with optional first-word-fall-through reads,
// almost-full/empty thresholds, an occupancy count, sticky error flags and a synchronous flush.
module sync_fifo_param #(
  parameter int unsigned DATASIZE = 64,
  parameter int unsigned ADDRSIZE = 7,
  parameter bit          FWFT     = 1'b0,
  parameter int unsigned AF_LEVEL = 2**ADDRSIZE - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned       DEPTH   = 2**ADDRSIZE;
  localparam logic [ADDRSIZE:0] PTR_INC = (ADDRSIZE+1)'(1);
  localparam logic [ADDRSIZE:0] AF_TH   = (ADDRSIZE+1)'(AF_LEVEL);
  localparam logic [ADDRSIZE:0] AE_TH   = (ADDRSIZE+1)'(AE_LEVEL);

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] count_q, count_d;
  logic              rempty_q, rempty_d;
  logic              wfull_q, wfull_d;
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              w_acc, r_acc;

  always_comb begin
    w_acc       = bus.w_en & ~wfull_q  & ~bus.clr;
    r_acc       = bus.r_en & ~rempty_q & ~bus.clr;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (w_acc) wptr_d = wptr_q + PTR_INC;
      if (r_acc) rptr_d = rptr_q + PTR_INC;
      if (bus.w_en & wfull_q)  overflow_d  = 1'b1;
      if (bus.r_en & rempty_q) underflow_d = 1'b1;
    end
    // Flags are derived from the post-update pointers so they are valid the cycle the pointers move.
    count_d        = wptr_d - rptr_d;
    rempty_d       = (wptr_d == rptr_d);
    wfull_d        = (wptr_d[ADDRSIZE] != rptr_d[ADDRSIZE]) &&
                     (wptr_d[ADDRSIZE-1:0] == rptr_d[ADDRSIZE-1:0]);
    almost_full_d  = (count_d >= AF_TH);
    almost_empty_d = (count_d <= AE_TH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      rempty_q       <= 1'b1;
      wfull_q        <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      rempty_q       <= rempty_d;
      wfull_q        <= wfull_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && !rst) mem[wptr_q[ADDRSIZE-1:0]] <= bus.wdata;
  end

  generate
    if (FWFT) begin : gen_fwft
      // Head entry shown combinationally; forced to zero while empty so no stale word leaks out.
      assign bus.rdata  = rempty_q ? '0 : mem[rptr_q[ADDRSIZE-1:0]];
      assign bus.rvalid = ~rempty_q;
    end else begin : gen_reg_read
      logic [DATASIZE-1:0] rdata_q, rdata_d;
      logic                rvalid_q, rvalid_d;

      always_comb begin
        rvalid_d = r_acc;
        rdata_d  = r_acc ? mem[rptr_q[ADDRSIZE-1:0]] : rdata_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign bus.rdata  = rdata_q;
      assign bus.rvalid = rvalid_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.rempty       = rempty_q;
  assign bus.wfull        = wfull_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
